// File: rtl/usb_cmd_pkg.sv
// Shared definitions for the USB command initiator.
// Holds the TX_MASS opcode, the initiator state enum and two helpers
// that classify the response tkeep field.
package usb_cmd_pkg;

  localparam logic [7:0] CMD_TX_MASS = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_CMD,
    ST_TX_LEN0,
    ST_TX_LEN1,
    ST_TX_LEN2,
    ST_TX_LEN3,
    ST_RX_DATA,
    ST_FINISH
  } state_e;

  // Number of valid byte lanes in a 4-lane beat.
  function automatic logic [2:0] keep_popcount(input logic [3:0] keep);
    keep_popcount = {2'b00, keep[0]} + {2'b00, keep[1]}
                  + {2'b00, keep[2]} + {2'b00, keep[3]};
  endfunction

  // Legal keep patterns are packed from lane 0 upward (including empty).
  function automatic logic keep_contiguous(input logic [3:0] keep);
    keep_contiguous = (keep == 4'b0000) || (keep == 4'b0001) ||
                      (keep == 4'b0011) || (keep == 4'b0111) ||
                      (keep == 4'b1111);
  endfunction

endpackage

// File: rtl/usb_mass_checker.sv
// Response checker for TX_MASS transactions.
// Ports: clk/rst; clear zeroes the counters at transaction start; beat marks
// an accepted response beat carrying tdata/tkeep/tlast; length is the
// captured L. byte_count and err_count are registered and change the cycle
// after each accepted beat.
module usb_mass_checker
  import usb_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        beat,
  input  logic [31:0] tdata,
  input  logic [3:0]  tkeep,
  input  logic        tlast,
  input  logic [31:0] length,
  output logic [31:0] byte_count,
  output logic [15:0] err_count
);

  logic [31:0] byte_count_q, byte_count_d;
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] exp_base;
  logic [31:0] lane_exp;
  logic [2:0]  err_inc;
  logic [16:0] err_sum;

  always_comb begin
    // Lane j of the beat carries the byte L-1-byte_count-j (32-bit wrap).
    exp_base = length - 32'd1 - byte_count_q;
    lane_exp = '0;
    err_inc  = '0;
    for (int j = 0; j < 4; j++) begin
      lane_exp = exp_base - 32'(j);
      if (tkeep[j] && (tdata[8*j +: 8] != lane_exp[7:0])) begin
        err_inc = err_inc + 3'd1;
      end
    end
    if (!keep_contiguous(tkeep)) begin
      err_inc = err_inc + 3'd1;
    end
    if (!tlast && (tkeep != 4'b1111)) begin
      err_inc = err_inc + 3'd1;
    end
    err_sum = {1'b0, err_count_q} + {14'd0, err_inc};

    byte_count_d = byte_count_q;
    err_count_d  = err_count_q;
    if (clear) begin
      byte_count_d = '0;
      err_count_d  = '0;
    end else if (beat) begin
      byte_count_d = byte_count_q + {29'd0, keep_popcount(tkeep)};
      err_count_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      byte_count_q <= byte_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign byte_count = byte_count_q;
  assign err_count  = err_count_q;

endmodule

// File: rtl/usb_cmd_initiator.sv
// Command initiator: serializes [CMD][LEN 4B LE] onto an 8-bit AXI-stream
// master and, for TX_MASS, checks the 32-bit response stream.
// Ports: start/cmd/length request a transaction; busy/done/pass/timeout
// report status; byte_count/err_count come from the response checker;
// o_t* is the command byte stream; i_t* is the response stream.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for start
// ST_TX_CMD  | presenting the command byte
// ST_TX_LEN0 | presenting L[7:0]
// ST_TX_LEN1 | presenting L[15:8]
// ST_TX_LEN2 | presenting L[23:16]
// ST_TX_LEN3 | presenting L[31:24]
// ST_RX_DATA | accepting response beats, timeout timer running
// ST_FINISH  | settle result; done pulses on the way to idle
module usb_cmd_initiator
  import usb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [31:0] length,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] byte_count,
  output logic [15:0] err_count,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic [7:0]  o_tdata,
  input  logic        i_tvalid,
  output logic        i_tready,
  input  logic [31:0] i_tdata,
  input  logic [3:0]  i_tkeep,
  input  logic        i_tlast
);

  localparam logic [31:0] TMR_LOAD = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] len_q, len_d;
  logic [31:0] tmr_q, tmr_d;
  logic        o_tvalid_q, o_tvalid_d;
  logic [7:0]  o_tdata_q, o_tdata_d;
  logic        i_tready_q, i_tready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        chk_clear;
  logic        tx_hs;
  logic        rx_beat;

  assign tx_hs   = o_tvalid_q && o_tready;
  // i_tready_q is only ever set while in ST_RX_DATA.
  assign rx_beat = i_tvalid && i_tready_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    tmr_d      = tmr_q;
    o_tvalid_d = o_tvalid_q;
    o_tdata_d  = o_tdata_q;
    i_tready_d = i_tready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    chk_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmd_d      = cmd;
          len_d      = length;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          chk_clear  = 1'b1;
          o_tvalid_d = 1'b1;
          o_tdata_d  = cmd;
          busy_d     = 1'b1;
          state_d    = ST_TX_CMD;
        end
      end
      ST_TX_CMD: if (tx_hs) begin
        o_tdata_d = len_q[7:0];
        state_d   = ST_TX_LEN0;
      end
      ST_TX_LEN0: if (tx_hs) begin
        o_tdata_d = len_q[15:8];
        state_d   = ST_TX_LEN1;
      end
      ST_TX_LEN1: if (tx_hs) begin
        o_tdata_d = len_q[23:16];
        state_d   = ST_TX_LEN2;
      end
      ST_TX_LEN2: if (tx_hs) begin
        o_tdata_d = len_q[31:24];
        state_d   = ST_TX_LEN3;
      end
      ST_TX_LEN3: if (tx_hs) begin
        o_tvalid_d = 1'b0;
        o_tdata_d  = '0;
        if (cmd_q == CMD_TX_MASS) begin
          i_tready_d = 1'b1;
          tmr_d      = TMR_LOAD;
          state_d    = ST_RX_DATA;
        end else begin
          pass_d  = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_RX_DATA: begin
        if (rx_beat) begin
          tmr_d = TMR_LOAD;
          if (i_tlast) begin
            i_tready_d = 1'b0;
            state_d    = ST_FINISH;
          end
        end else if (tmr_q == '0) begin
          timeout_d  = 1'b1;
          i_tready_d = 1'b0;
          state_d    = ST_FINISH;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      ST_FINISH: begin
        // Counters now reflect the final beat, so the verdict is settled here.
        if ((cmd_q == CMD_TX_MASS) && !timeout_q) begin
          pass_d = (err_count == 16'd0) && (byte_count == len_q);
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      i_tready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      tmr_q      <= tmr_d;
      o_tvalid_q <= o_tvalid_d;
      o_tdata_q  <= o_tdata_d;
      i_tready_q <= i_tready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  usb_mass_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .clear      (chk_clear),
    .beat       (rx_beat),
    .tdata      (i_tdata),
    .tkeep      (i_tkeep),
    .tlast      (i_tlast),
    .length     (len_q),
    .byte_count (byte_count),
    .err_count  (err_count)
  );

  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign i_tready = i_tready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_usb_cmd_initiator.sv
module tb_usb_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  cmd;
  logic [31:0] length;
  logic        busy, done, pass, timeout;
  logic [31:0] byte_count;
  logic [15:0] err_count;
  logic        o_tvalid, o_tready;
  logic [7:0]  o_tdata;
  logic        i_tvalid, i_tready, i_tlast;
  logic [31:0] i_tdata;
  logic [3:0]  i_tkeep;

  int checks = 0;
  int failures = 0;

  logic [31:0] bq_data[$];
  logic [3:0]  bq_keep[$];
  logic        bq_last[$];

  usb_cmd_initiator #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .length(length),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .byte_count(byte_count), .err_count(err_count),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
    .i_tkeep(i_tkeep), .i_tlast(i_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Well-formed handler response for length l, optionally with one lane flipped.
  task automatic build_resp(input logic [31:0] l, input int bad_beat, input int bad_lane);
    int n;
    logic [31:0] d, e;
    bq_data.delete(); bq_keep.delete(); bq_last.delete();
    n = 0;
    while (int'(l) - n >= 4) begin
      for (int j = 0; j < 4; j++) begin
        e = l - 32'd1 - 32'(n) - 32'(j);
        d[8*j +: 8] = e[7:0];
      end
      bq_data.push_back(d); bq_keep.push_back(4'b1111); bq_last.push_back(1'b0);
      n += 4;
    end
    d = $urandom;
    for (int j = 0; j < int'(l) - n; j++) begin
      e = l - 32'd1 - 32'(n) - 32'(j);
      d[8*j +: 8] = e[7:0];
    end
    bq_data.push_back(d);
    bq_keep.push_back(4'((1 << (int'(l) - n)) - 1));
    bq_last.push_back(1'b1);
    if (bad_beat >= 0 && bad_beat < bq_data.size()) begin
      d = bq_data[bad_beat];
      d[8*bad_lane +: 8] = d[8*bad_lane +: 8] ^ 8'hA5;
      bq_data[bad_beat] = d;
    end
  endtask

  task automatic finish_checks(input logic p, input logic to, input logic [31:0] bc, input logic [31:0] ec);
    chk_eq("done", done, 1'b1);
    chk_eq("pass", pass, p);
    chk_eq("timeout", timeout, to);
    chk_eq("byte_count", byte_count, bc);
    chk_eq("err_count", err_count, ec);
    chk_eq("busy_at_done", busy, 1'b0);
    step();
    chk_eq("done_pulse", done, 1'b0);
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [31:0] l, input bit stall,
                         input bit gaps, input bit no_resp);
    logic [7:0] hdr[$];
    logic [7:0] exp_hdr [5];
    logic [7:0] prev_data;
    logic [31:0] e, dat;
    logic [3:0] kp;
    logic lst, acc;
    bit prev_stall, fin;
    int cyc, bound, rdy_cnt, m_bytes, m_err, base;

    exp_hdr[0] = c; exp_hdr[1] = l[7:0]; exp_hdr[2] = l[15:8];
    exp_hdr[3] = l[23:16]; exp_hdr[4] = l[31:24];

    start = 1'b1; cmd = c; length = l;
    step();
    start = 1'b0;
    chk_eq("start_busy", busy, 1'b1);
    chk_eq("start_pass_clr", pass, 1'b0);
    chk_eq("start_bc_clr", byte_count, 0);
    chk_eq("start_ec_clr", err_count, 0);

    cyc = 0; prev_stall = 0; prev_data = '0;
    while (hdr.size() < 5 && cyc < 200) begin
      o_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) chk_eq("hdr_hold", o_tdata, prev_data);
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      if (o_tvalid && o_tready) hdr.push_back(o_tdata);
      step();
      cyc++;
    end
    o_tready = 1'b0;
    chk_eq("hdr_count", hdr.size(), 5);
    for (int i = 0; i < hdr.size() && i < 5; i++) chk_eq("hdr_byte", hdr[i], exp_hdr[i]);
    chk_eq("post_hdr_tvalid", o_tvalid, 1'b0);
    chk_eq("post_hdr_tready", i_tready, (c == 8'h01));
    chk_eq("post_hdr_done", done, 1'b0);

    if (c != 8'h01) begin
      step();
      finish_checks(1'b1, 1'b0, 0, 0);
    end else if (no_resp) begin
      rdy_cnt = 0; cyc = 0;
      while (!done && cyc < 300) begin
        if (i_tready) rdy_cnt++;
        step();
        cyc++;
      end
      chk_eq("timeout_ready_cycles", rdy_cnt, 64);
      finish_checks(1'b0, 1'b1, 0, 0);
    end else begin
      m_bytes = 0; m_err = 0; fin = 0; cyc = 0;
      bound = int'(l) + 400;
      while (!fin && cyc < bound) begin
        if (!i_tvalid && bq_keep.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
          i_tdata = bq_data[0]; i_tkeep = bq_keep[0]; i_tlast = bq_last[0];
          i_tvalid = 1'b1;
        end
        acc = i_tvalid && i_tready;
        dat = i_tdata; kp = i_tkeep; lst = i_tlast;
        step();
        cyc++;
        if (acc) begin
          void'(bq_data.pop_front()); void'(bq_keep.pop_front()); void'(bq_last.pop_front());
          i_tvalid = 1'b0;
          base = m_bytes;
          if (!(kp inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111})) m_err++;
          if (!lst && kp != 4'b1111) m_err++;
          for (int j = 0; j < 4; j++) begin
            if (kp[j]) begin
              e = l - 32'd1 - 32'(base) - 32'(j);
              if (dat[8*j +: 8] != e[7:0]) m_err++;
              m_bytes++;
            end
          end
          chk_eq("beat_bc", byte_count, m_bytes);
          chk_eq("beat_ec", err_count, m_err);
          if (lst) begin
            fin = 1;
            chk_eq("done_early", done, 1'b0);
          end
        end
      end
      chk_eq("rx_finished_in_bound", fin, 1'b1);
      step();
      finish_checks((m_err == 0) && (m_bytes == int'(l)), 1'b0, m_bytes, m_err);
    end
  endtask

  initial begin
    logic [7:0] c;
    logic [31:0] l;
    rst = 1'b1; start = 0; cmd = 0; length = 0; o_tready = 0;
    i_tvalid = 0; i_tdata = 0; i_tkeep = 0; i_tlast = 0;
    step(); step();
    chk_eq("rst_o_tvalid", o_tvalid, 0);
    chk_eq("rst_o_tdata", o_tdata, 0);
    chk_eq("rst_i_tready", i_tready, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_pass", pass, 0);
    chk_eq("rst_timeout", timeout, 0);
    chk_eq("rst_bc", byte_count, 0);
    chk_eq("rst_ec", err_count, 0);
    rst = 1'b0;
    step();

    build_resp(32'd10, -1, 0);    run_txn(8'h01, 32'd10, 0, 0, 0);
    build_resp(32'd8, -1, 0);     run_txn(8'h01, 32'd8, 0, 1, 0);
    build_resp(32'd5, 0, 1);      run_txn(8'h01, 32'd5, 0, 0, 0);
    chk_eq("l5_corrupt_err", err_count, 1);
    run_txn(8'h07, 32'd100, 1, 0, 0);
    build_resp(32'd10000, -1, 0); run_txn(8'h01, 32'd10000, 1, 0, 0);
    run_txn(8'h01, 32'd4, 0, 0, 1);
    build_resp(32'd0, -1, 0);     run_txn(8'h01, 32'd0, 1, 1, 0);

    // short non-last beat: one framing error
    bq_data.delete(); bq_keep.delete(); bq_last.delete();
    bq_data.push_back(32'h00030405); bq_keep.push_back(4'b0111); bq_last.push_back(1'b0);
    bq_data.push_back(32'h00000102); bq_keep.push_back(4'b0111); bq_last.push_back(1'b1);
    run_txn(8'h01, 32'd6, 0, 0, 0);
    chk_eq("short_beat_err", err_count, 1);
    // non-contiguous keep on the last beat
    bq_data.delete(); bq_keep.delete(); bq_last.delete();
    bq_data.push_back(32'h00FF0001); bq_keep.push_back(4'b0101); bq_last.push_back(1'b1);
    run_txn(8'h01, 32'd2, 0, 0, 0);
    chk_eq("noncontig_err", err_count, 1);

    // reset while presenting L[23:16]
    start = 1'b1; cmd = 8'h01; length = 32'h11223344; o_tready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk_eq("len2_data", o_tdata, 8'h22);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_tvalid", o_tvalid, 0);
    chk_eq("mid_rst_busy", busy, 0);
    chk_eq("mid_rst_tdata", o_tdata, 0);
    o_tready = 1'b0;
    step();
    rst = 1'b0;
    step();
    build_resp(32'd3, -1, 0); run_txn(8'h01, 32'd3, 0, 0, 0);

    for (int t = 0; t < 10; t++) begin
      c = ($urandom_range(0, 2) != 0) ? 8'h01 : 8'($urandom_range(2, 255));
      l = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
      build_resp(l, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 10)) : -1,
                 int'($urandom_range(0, 3)));
      run_txn(c, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_cmd_initiator.md
# usb_cmd_initiator

Command initiator and response checker for the USB command protocol. It builds a `[CMD][LENGTH(4B,LE)]` byte stream from a start request and sends it into the command handler's 8-bit receive port. For `TX_MASS` (0x01), it then consumes the handler's 32-bit response stream, checks the descending byte pattern and reports the result. It is used for on-chip loopback self-test of the command path and as the bench driver for the handler.

## Interface
- `TIMEOUT_CYCLES`, default 1048576: maximum idle cycles between accepted response beats before the transaction is aborted.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a transaction; sampled only in IDLE.
- `cmd`  in  8  command byte, captured on `start`.
- `length`  in  32  length field, captured on `start`.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse at transaction end.
- `pass`  out  1  result, held until the next `start`.
- `timeout`  out  1  response timed out, held until the next `start`.
- `byte_count`  out  32  response bytes received (keep-qualified).
- `err_count`  out  16  mismatching bytes plus framing errors; saturates at 0xFFFF.
- `o_tvalid`  out  1, `o_tready`  in  1, `o_tdata`  out  8: command byte stream, AXI-stream master.
- `i_tvalid`  in  1, `i_tready`  out  1, `i_tdata`  in  32, `i_tkeep`  in  4, `i_tlast`  in  1: response stream, AXI-stream slave.

## Operation
- States: IDLE, TX_CMD, TX_LEN0, TX_LEN1, TX_LEN2, TX_LEN3, RX_DATA, FINISH.
- IDLE → TX_CMD on `start`. On that transition:
  - capture `cmd` into C and `length` into L;
  - clear `pass`, `timeout`, `byte_count` and `err_count`.
- TX_CMD sends C.
- TX_LEN0..3 send L[7:0], L[15:8], L[23:16] and L[31:24] in that order.
- Each TX state advances only on `o_tvalid && o_tready`.
- After the TX_LEN3 handshake:
  - C == 0x01 → RX_DATA;
  - any other C → FINISH with `pass`=1 and `byte_count`=0 (no response is expected).
- RX_DATA: `i_tready`=1 and the state is active. `i_tready` is 0 in every other state.
- Expected byte n (0-based over the whole response) is (L−1−n)[7:0].
- Per accepted beat:
  - let e = L−1−`byte_count`;
  - lane j with `i_tkeep[j]`=1 must equal (e−j)[7:0];
  - each mismatching lane adds 1 to `err_count`;
  - `byte_count` += popcount(`i_tkeep`).
- Framing errors (each adds 1 to `err_count`):
  - `i_tkeep` not one of 0000, 0001, 0011, 0111, 1111;
  - a non-last beat with `i_tkeep` ≠ 1111.
- A beat with `i_tkeep`=0000 and `i_tlast`=1 is legal and adds 0 bytes. The handler emits this when L is a multiple of 4.
- On acceptance of the `i_tlast` beat → FINISH. `pass` = (final `err_count`==0) && (final `byte_count`==L).
- Timeout counter:
  - counts cycles in RX_DATA;
  - clears on every accepted beat;
  - reaching `TIMEOUT_CYCLES` → FINISH with `timeout`=1 and `pass`=0.
- FINISH: `done`=1 for one cycle, then IDLE.
- `start` while not in IDLE is ignored.

## Timing
- Reset values: `o_tvalid`, `o_tdata`, `i_tready`, `busy`, `done`, `pass`, `timeout`, `byte_count` and `err_count` are all 0; state is IDLE.
- All outputs are registered.
- `start` at cycle 0 → `o_tvalid`=1 with `o_tdata`=C at cycle 1.
- With `o_tready` held high, one byte transfers per cycle: 5 cycles for the command header.
- `o_tdata` is stable while `o_tvalid`=1 and `o_tready`=0.
- Cycle after the TX_LEN3 handshake: `o_tvalid`=0 and, for 0x01, `i_tready`=1.
- Checker updates `byte_count` and `err_count` the cycle after each accepted beat.
- `done` rises one cycle after the counters reflect the last beat.
- `rst` mid-transaction: immediate return to IDLE with all outputs at reset values. A partially sent header is abandoned.
- Arithmetic: 32-bit modulo on L−1−n. L=0 expects exactly one empty tlast beat.

## Structure
- Package `usb_cmd_pkg` holds:
  - `CMD_TX_MASS` = 8'h01;
  - the state enum;
  - a `keep_popcount` function;
  - a `keep_contiguous` function.
- Sub-module `usb_mass_checker` contains the RX_DATA datapath: the expected-byte compare, counters and framing checks. The parent keeps the FSM and the header serializer.

## Test plan
- C=0x01, L=10, handler connected:
  - beats: {6,7,8,9}/1111, {2,3,4,5}/1111, {x,x,0,1}/0011 with tlast;
  - required: `byte_count`=10, `err_count`=0, `pass`=1, one `done` pulse.
- C=0x01, L=8: final beat has tkeep=0000 and tlast → `pass`=1, `byte_count`=8.
- C=0x01, L=5, lane 1 of the first beat corrupted → `err_count`=1, `pass`=0.
- C=0x07, L=100 → header bytes 07 64 00 00 00, no RX, `pass`=1, `byte_count`=0.
- `o_tready` toggled randomly during the header → bytes 01 10 27 00 00 (L=10000) unchanged and held while stalled.
- C=0x01, L=4 with no response and `TIMEOUT_CYCLES`=64 → `timeout`=1, `pass`=0, `done` at 64 cycles.
- `rst` asserted during TX_LEN2 → `o_tvalid`=0 immediately; a new `start` sends a full header.
